// File: rtl/reg_scoreboard.sv
// Per-register in-flight writer scoreboard for the decode stage.
// Counts outstanding writers and "late" writers; stalls D on a late source.
module reg_scoreboard #(
    parameter int MAX_INFLIGHT = 3,
    parameter int NREG         = 32,
    localparam int CW          = $clog2(MAX_INFLIGHT + 1),
    localparam int AW          = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            issue_valid,
    input  logic            issue_regwrite,
    input  logic            issue_late,
    input  logic [AW-1:0]   issue_dst,
    input  logic [AW-1:0]   issue_ra1,
    input  logic [AW-1:0]   issue_ra2,
    input  logic            ready_valid,
    input  logic [AW-1:0]   ready_dst,
    input  logic            wb_valid,
    input  logic [AW-1:0]   wb_dst,
    input  logic            flush,
    output logic            stall,
    output logic [NREG-1:0] busy,
    output logic [NREG-1:0] late_mask,
    output logic            err
);

    logic [CW-1:0]   r_cnt      [NREG];
    logic [CW-1:0]   r_late_cnt [NREG];
    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] r_late_mask;
    logic            r_err;

    logic [CW-1:0]   w_cnt_nxt  [NREG];
    logic [CW-1:0]   w_late_nxt [NREG];
    logic [CW-1:0]   w_late_cand[NREG];
    logic [NREG-1:0] w_inc;
    logic [NREG-1:0] w_wb;
    logic [NREG-1:0] w_rdy;
    logic [NREG-1:0] w_linc;
    logic            w_accept;
    logic            w_err_set;
    logic            w_stall;

    // Stall on any outstanding late writer of a nonzero source, from registered state only.
    always_comb begin
        w_stall = ((issue_ra1 != AW'(0)) && (r_late_cnt[issue_ra1] != CW'(0))) ||
                  ((issue_ra2 != AW'(0)) && (r_late_cnt[issue_ra2] != CW'(0)));
    end

    // Net per-register counter update with overflow/underflow/invariant checks.
    always_comb begin
        w_accept  = issue_valid && issue_regwrite && (issue_dst != AW'(0)) && !w_stall && !flush;
        w_err_set = 1'b0;
        w_inc     = '0;
        w_wb      = '0;
        w_rdy     = '0;
        w_linc    = '0;
        for (int r = 0; r < NREG; r++) begin
            w_cnt_nxt[r]   = r_cnt[r];
            w_late_nxt[r]  = r_late_cnt[r];
            w_late_cand[r] = r_late_cnt[r];
        end
        for (int r = 1; r < NREG; r++) begin
            w_inc[r] = w_accept && (issue_dst == AW'(r));
            w_wb[r]  = wb_valid && !flush && (wb_dst == AW'(r));
            w_rdy[r] = ready_valid && !flush && (ready_dst == AW'(r));
            // A full register only takes a new writer when one retires in the same cycle.
            if (w_inc[r] && !w_wb[r] && (r_cnt[r] == CW'(MAX_INFLIGHT))) begin
                w_inc[r]  = 1'b0;
                w_err_set = 1'b1;
            end else if (w_wb[r] && !w_inc[r] && (r_cnt[r] == CW'(0))) begin
                w_wb[r]   = 1'b0;
                w_err_set = 1'b1;
            end else begin
                w_cnt_nxt[r] = r_cnt[r];
            end
            w_cnt_nxt[r] = r_cnt[r] + CW'(w_inc[r]) - CW'(w_wb[r]);
            w_linc[r]    = w_inc[r] && issue_late;
            if (w_rdy[r] && !w_linc[r] && (r_late_cnt[r] == CW'(0))) begin
                w_rdy[r]  = 1'b0;
                w_err_set = 1'b1;
            end else begin
                w_late_cand[r] = r_late_cnt[r];
            end
            w_late_cand[r] = r_late_cnt[r] + CW'(w_linc[r]) - CW'(w_rdy[r]);
            if (w_late_cand[r] > w_cnt_nxt[r]) begin
                w_late_nxt[r] = r_late_cnt[r];
                w_err_set     = 1'b1;
            end else begin
                w_late_nxt[r] = w_late_cand[r];
            end
        end
        if (flush) begin
            for (int r = 0; r < NREG; r++) begin
                w_cnt_nxt[r]  = CW'(0);
                w_late_nxt[r] = CW'(0);
            end
        end else begin
            w_cnt_nxt[0]  = CW'(0);
            w_late_nxt[0] = CW'(0);
        end
    end

    // State registers; busy/late_mask mirror the next counter state.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++) begin
                r_cnt[r]      <= CW'(0);
                r_late_cnt[r] <= CW'(0);
            end
            r_busy      <= '0;
            r_late_mask <= '0;
            r_err       <= 1'b0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                r_cnt[r]       <= w_cnt_nxt[r];
                r_late_cnt[r]  <= w_late_nxt[r];
                r_busy[r]      <= (w_cnt_nxt[r] != CW'(0));
                r_late_mask[r] <= (w_late_nxt[r] != CW'(0));
            end
            r_err <= r_err | w_err_set;
        end
    end

    assign stall     = w_stall;
    assign busy      = r_busy;
    assign late_mask = r_late_mask;
    assign err       = r_err;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed scoreboard bench for reg_scoreboard: stimulus pushes expected
// post-edge outputs into a queue; a monitor pops and compares each cycle.
module tb_reg_scoreboard;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        issue_valid = 1'b0, issue_regwrite = 1'b0, issue_late = 1'b0;
    logic [4:0]  issue_dst = 5'd0, issue_ra1 = 5'd0, issue_ra2 = 5'd0;
    logic        ready_valid = 1'b0;
    logic [4:0]  ready_dst = 5'd0;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_dst = 5'd0;
    logic        flush = 1'b0;
    logic        stall;
    logic [31:0] busy, late_mask;
    logic        err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       name;
        logic [31:0] busy;
        logic [31:0] lm;
        logic        stall;
        logic        err;
    } exp_t;
    exp_t q[$];

    reg_scoreboard dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_regwrite(issue_regwrite), .issue_late(issue_late),
        .issue_dst(issue_dst), .issue_ra1(issue_ra1), .issue_ra2(issue_ra2),
        .ready_valid(ready_valid), .ready_dst(ready_dst),
        .wb_valid(wb_valid), .wb_dst(wb_dst), .flush(flush),
        .stall(stall), .busy(busy), .late_mask(late_mask), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input string field, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s.%s: got %h expected %h", name, field, act, exp);
        end
    endtask

    // Monitor: compare the registered outputs shortly after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk(e.name, "busy",      busy,              e.busy);
                chk(e.name, "late_mask", late_mask,         e.lm);
                chk(e.name, "stall",     {31'd0, stall},    {31'd0, e.stall});
                chk(e.name, "err",       {31'd0, err},      {31'd0, e.err});
            end
        end
    end

    // Drive one cycle of inputs and queue the outputs expected after the edge.
    task automatic step(input string name, input logic rst, input logic fl,
                        input logic iv, input logic late, input logic [4:0] dst,
                        input logic [4:0] ra1, input logic [4:0] ra2,
                        input logic rv, input logic [4:0] rdst,
                        input logic wv, input logic [4:0] wdst,
                        input logic [31:0] eb, input logic [31:0] elm,
                        input logic es, input logic ee);
        exp_t e;
        @(negedge clk);
        #1;
        reset = rst; flush = fl;
        issue_valid = iv; issue_regwrite = iv; issue_late = late; issue_dst = dst;
        issue_ra1 = ra1; issue_ra2 = ra2;
        ready_valid = rv; ready_dst = rdst;
        wb_valid = wv; wb_dst = wdst;
        e.name = name; e.busy = eb; e.lm = elm; e.stall = es; e.err = ee;
        q.push_back(e);
    endtask

    initial begin
        //     name        rst  fl   iv   lt   dst    ra1    ra2    rv   rdst   wv   wdst   busy          late_mask     st   err
        step("rst0",      1'b1,1'b0,1'b1,1'b1,5'd5, 5'd5, 5'd0, 1'b0,5'd0, 1'b0,5'd0, 32'h0,        32'h0,        1'b0,1'b0);
        step("rst1",      1'b1,1'b0,1'b1,1'b1,5'd5, 5'd5, 5'd0, 1'b0,5'd0, 1'b0,5'd0, 32'h0,        32'h0,        1'b0,1'b0);
        // Load-use on x5
        step("ld_issue",  1'b0,1'b0,1'b1,1'b1,5'd5, 5'd0, 5'd0, 1'b0,5'd0, 1'b0,5'd0, 32'h20,       32'h20,       1'b0,1'b0);
        step("ld_stall",  1'b0,1'b0,1'b1,1'b0,5'd8, 5'd5, 5'd0, 1'b0,5'd0, 1'b0,5'd0, 32'h20,       32'h20,       1'b1,1'b0);
        step("ld_ready",  1'b0,1'b0,1'b0,1'b0,5'd0, 5'd5, 5'd0, 1'b1,5'd5, 1'b0,5'd0, 32'h20,       32'h0,        1'b0,1'b0);
        step("ld_wb",     1'b0,1'b0,1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,5'd0, 1'b1,5'd5, 32'h0,        32'h0,        1'b0,1'b0);
        // ALU producer x7 and x0 no-op
        step("alu_issue", 1'b0,1'b0,1'b1,1'b0,5'd7, 5'd0, 5'd7, 1'b0,5'd0, 1'b0,5'd0, 32'h80,       32'h0,        1'b0,1'b0);
        step("x0_issue",  1'b0,1'b0,1'b1,1'b1,5'd0, 5'd0, 5'd7, 1'b0,5'd0, 1'b0,5'd0, 32'h80,       32'h0,        1'b0,1'b0);
        // Saturate x9
        step("x9_a",      1'b0,1'b0,1'b1,1'b0,5'd9, 5'd0, 5'd0, 1'b0,5'd0, 1'b0,5'd0, 32'h280,      32'h0,        1'b0,1'b0);
        step("x9_b",      1'b0,1'b0,1'b1,1'b0,5'd9, 5'd0, 5'd0, 1'b0,5'd0, 1'b0,5'd0, 32'h280,      32'h0,        1'b0,1'b0);
        step("x9_c",      1'b0,1'b0,1'b1,1'b0,5'd9, 5'd0, 5'd0, 1'b0,5'd0, 1'b0,5'd0, 32'h280,      32'h0,        1'b0,1'b0);
        step("x9_iss_wb", 1'b0,1'b0,1'b1,1'b0,5'd9, 5'd0, 5'd0, 1'b0,5'd0, 1'b1,5'd9, 32'h280,      32'h0,        1'b0,1'b0);
        step("x9_ovf",    1'b0,1'b0,1'b1,1'b0,5'd9, 5'd0, 5'd0, 1'b0,5'd0, 1'b0,5'd0, 32'h280,      32'h0,        1'b0,1'b1);
        step("x9_wb1",    1'b0,1'b0,1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,5'd0, 1'b1,5'd9, 32'h280,      32'h0,        1'b0,1'b1);
        step("x9_wb2",    1'b0,1'b0,1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,5'd0, 1'b1,5'd9, 32'h280,      32'h0,        1'b0,1'b1);
        step("x9_wb3",    1'b0,1'b0,1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,5'd0, 1'b1,5'd9, 32'h80,       32'h0,        1'b0,1'b1);
        // Underflow on wb, sticky, then on ready
        step("rst2",      1'b1,1'b0,1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,5'd0, 1'b0,5'd0, 32'h0,        32'h0,        1'b0,1'b0);
        step("wb_unf",    1'b0,1'b0,1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,5'd0, 1'b1,5'd12,32'h0,        32'h0,        1'b0,1'b1);
        step("err_stick", 1'b0,1'b0,1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,5'd0, 1'b1,5'd0, 32'h0,        32'h0,        1'b0,1'b1);
        step("rst3",      1'b1,1'b0,1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,5'd0, 1'b0,5'd0, 32'h0,        32'h0,        1'b0,1'b0);
        step("rdy_x0",    1'b0,1'b0,1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b1,5'd0, 1'b0,5'd0, 32'h0,        32'h0,        1'b0,1'b0);
        step("rdy_unf",   1'b0,1'b0,1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b1,5'd12,1'b0,5'd0, 32'h0,        32'h0,        1'b0,1'b1);
        // Flush mid-operation
        step("rst4",      1'b1,1'b0,1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,5'd0, 1'b0,5'd0, 32'h0,        32'h0,        1'b0,1'b0);
        step("fl_x3",     1'b0,1'b0,1'b1,1'b1,5'd3, 5'd0, 5'd0, 1'b0,5'd0, 1'b0,5'd0, 32'h8,        32'h8,        1'b0,1'b0);
        step("fl_x4",     1'b0,1'b0,1'b1,1'b0,5'd4, 5'd0, 5'd0, 1'b0,5'd0, 1'b0,5'd0, 32'h18,       32'h8,        1'b0,1'b0);
        step("fl_err",    1'b0,1'b0,1'b0,1'b0,5'd0, 5'd3, 5'd0, 1'b0,5'd0, 1'b1,5'd12,32'h18,       32'h8,        1'b1,1'b1);
        step("flush",     1'b0,1'b1,1'b1,1'b0,5'd6, 5'd0, 5'd0, 1'b1,5'd3, 1'b1,5'd4, 32'h0,        32'h0,        1'b0,1'b1);
        step("post_fl",   1'b0,1'b0,1'b0,1'b0,5'd0, 5'd3, 5'd6, 1'b0,5'd0, 1'b0,5'd0, 32'h0,        32'h0,        1'b0,1'b1);
        step("rst_mid",   1'b1,1'b0,1'b1,1'b1,5'd3, 5'd3, 5'd0, 1'b0,5'd0, 1'b0,5'd0, 32'h0,        32'h0,        1'b0,1'b0);
        step("idle",      1'b0,1'b0,1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,5'd0, 1'b0,5'd0, 32'h0,        32'h0,        1'b0,1'b0);
        repeat (3) @(posedge clk);
        #3;
        chk("drain", "queue_left", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Producer-side companion to the decode-stage forwarding mux.
- Tracks every in-flight register write from issue (D->E) through writeback.
- Marks destinations whose value cannot yet be reached by the E/M forwarding paths ("late" producers: loads, multi-cycle mul/div).
- Drives the decode-stage stall so the forwarding mux only ever sees consumers whose operands are forwardable or committed.

Parameters:
- MAX_INFLIGHT, 3, max simultaneously outstanding writers per architectural register; counter width CW = clog2(MAX_INFLIGHT+1).
- NREG, 32, number of architectural registers; index width 5, x0 never tracked.

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- issue_valid  input  1  instruction leaving D for E this cycle
- issue_regwrite  input  1  issuing instruction writes a register
- issue_late  input  1  result not available on E-stage forward path (load / multi-cycle)
- issue_dst  input  5  destination register of issuing instruction
- issue_ra1  input  5  source register 1 of the instruction currently in D
- issue_ra2  input  5  source register 2 of the instruction currently in D
- ready_valid  input  1  a late producer's result became forwardable this cycle
- ready_dst  input  5  destination of that producer
- wb_valid  input  1  writeback commits a register write this cycle
- wb_dst  input  5  committed destination
- flush  input  1  entire in-flight writer set squashed
- stall  output  1  D must hold; combinational from registered state and issue_ra1/ra2
- busy  output  NREG  registered, bit r = cnt[r] != 0
- late_mask  output  NREG  registered, bit r = late_cnt[r] != 0
- err  output  1  sticky protocol-violation flag

Behaviour:
- State: per register r, cnt[r] and late_cnt[r] (CW bits each); err flop. Entry 0 is held at zero permanently.
- Reset (sync, reset=1 at edge):
  - all cnt/late_cnt = 0, err = 0
  - busy = 0, late_mask = 0, hence stall = 0
  - reset overrides every other input in the same cycle, including mid-operation.
- stall = (issue_ra1 != 0 && late_cnt[issue_ra1] != 0) || (issue_ra2 != 0 && late_cnt[issue_ra2] != 0).
  - Depends only on current state; issue/ready/wb inputs of the same cycle do not affect it.
  - Conservative: any outstanding late writer of a source stalls, even if a younger non-late writer exists.
- Issue accept = issue_valid && issue_regwrite && issue_dst != 0 && !stall && !flush.
- Overflow: if cnt[issue_dst] == MAX_INFLIGHT and no same-cycle wb to issue_dst, the issue is dropped and err <= 1.
- Accepted issue: cnt[dst] += 1; late_cnt[dst] += 1 if issue_late.
- Ready event (ready_valid, ready_dst != 0):
  - late_cnt[dst] -= 1
  - if late_cnt[dst] == 0: ignored, err <= 1
- Writeback event (wb_valid, wb_dst != 0):
  - cnt[dst] -= 1
  - if cnt[dst] == 0: ignored, err <= 1
  - late_cnt is not touched by wb.
- Simultaneous events on the same register resolve as a net count: issue +1, wb -1 (cnt); issue_late +1, ready -1 (late_cnt).
  - Example: issue + wb on the same reg leaves cnt unchanged.
  - Underflow/overflow checks use the net result.
- Invariant: late_cnt[r] <= cnt[r]. Any update that would violate it is suppressed for late_cnt and sets err.
- flush (sync):
  - next-cycle all cnt/late_cnt = 0
  - same-cycle issue/ready/wb are ignored
  - err is retained
- busy/late_mask update one cycle after the event that changes the counters (registered view of next state).
- Latency:
  - issue of a late writer -> stall visible for a matching source the next cycle
  - ready -> stall drops the next cycle
  - wb -> busy bit clears the next cycle
- Indices equal to 0 on any event port are no-ops and never set err.

Test Plan:
- Reset: hold reset 2 cycles with issue_valid=1, dst=5, late=1 -> busy=0, late_mask=0, stall=0, err=0 after release.
- Load-use:
  - issue dst=5, late=1; next cycle issue_ra1=5 -> stall=1, late_mask[5]=1.
  - ready_dst=5 -> stall=0 next cycle.
  - wb_dst=5 -> busy[5]=0 next cycle.
- ALU producer: issue dst=7, late=0 -> busy[7]=1, late_mask[7]=0; issue_ra2=7 -> stall=0. issue dst=0 -> no state change.
- Counting:
  - three issues to x9 -> cnt saturates at 3.
  - fourth issue alone -> dropped, err=1.
  - fourth issue with same-cycle wb_dst=9 -> accepted, busy[9] stays 1, err unchanged.
- Underflow: wb_dst=12 with busy[12]=0 -> no change, err=1 sticky until reset. ready_dst=12 with late_mask[12]=0 -> err=1.
- Flush mid-operation:
  - x3 late outstanding, x4 busy; assert flush with same-cycle issue dst=6 -> next cycle busy=0, late_mask=0, stall=0, x6 not tracked, err retained.
